// File: rtl/muldiv_alu_seq.sv
// muldiv_alu_seq
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit
// ALU for its per-bit add/subtract. While in ITER it drives alu_sel high and
// presents its operands on alu_a/alu_b/alu_fun; the ALU result comes back
// combinationally on alu_s in the same cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, op           launch request (sampled in IDLE), operation select
//                       (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   rs_val, rt_val      multiplicand/dividend, multiplier/divisor
//   busy, done          in-flight flag, one-cycle result-valid pulse
//   hi, lo              product[63:32]/remainder, product[31:0]/quotient
//   alu_sel             block owns the ALU this cycle
//   alu_a, alu_b        ALU operands
//   alu_fun, alu_sign   ALU function code, ALU sign input (always 0)
//   alu_s               ALU result
module muldiv_alu_seq #(
    parameter logic [5:0] ALU_ADD = 6'b000000,
    parameter logic [5:0] ALU_SUB = 6'b000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_s
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] rs_r;
    logic [31:0] rt_r;
    logic [31:0] ma_r;
    logic [31:0] mb_r;
    // w_hi_r is acc (MUL) or rem (DIV); w_lo_r is lo_w (MUL) or q (DIV).
    logic [31:0] w_hi_r;
    logic [31:0] w_lo_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        dz_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [31:0] prep_ma_s;
    logic [31:0] prep_mb_s;
    logic [31:0] div_t_s;
    logic        div_take_s;
    logic        mul_carry_s;
    logic        alu_sel_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [5:0]  alu_fun_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // |0x80000000| wraps back to 0x80000000, which is what the unsigned core wants.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    assign prep_ma_s   = op_r[0] ? abs32(rs_r) : rs_r;
    assign prep_mb_s   = op_r[0] ? abs32(rt_r) : rt_r;
    // Restoring division: shift the next dividend bit into the partial remainder.
    // rem[31] set means the shifted value is 33 bits wide and always exceeds mb.
    assign div_t_s     = {w_hi_r[30:0], w_lo_r[31]};
    assign div_take_s  = w_hi_r[31] | (div_t_s >= mb_r);
    // ALU add wrapped iff the sum fell below the accumulator.
    assign mul_carry_s = (alu_s < w_hi_r);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_PREP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREP: begin
                if (op_r[1] && (rt_r == 32'd0)) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_r == 5'd31) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_ITER;
                end
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // ALU ownership and operand selection; quiet zeros outside ITER.
    always_comb begin
        alu_sel_s = 1'b0;
        alu_a_s   = 32'd0;
        alu_b_s   = 32'd0;
        alu_fun_s = 6'd0;
        if (state_r == S_ITER) begin
            alu_sel_s = 1'b1;
            if (op_r[1]) begin
                alu_a_s   = div_t_s;
                alu_b_s   = mb_r;
                alu_fun_s = ALU_SUB;
            end else begin
                alu_a_s   = w_hi_r;
                alu_b_s   = w_lo_r[0] ? ma_r : 32'd0;
                alu_fun_s = ALU_ADD;
            end
        end else begin
            alu_sel_s = 1'b0;
            alu_a_s   = 32'd0;
            alu_b_s   = 32'd0;
            alu_fun_s = 6'd0;
        end
    end

    // Operand capture, iteration datapath, sign fix-up and handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= 5'd0;
            op_r    <= 2'd0;
            rs_r    <= 32'd0;
            rt_r    <= 32'd0;
            ma_r    <= 32'd0;
            mb_r    <= 32'd0;
            w_hi_r  <= 32'd0;
            w_lo_r  <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        rs_r   <= rs_val;
                        rt_r   <= rt_val;
                        busy_r <= 1'b1;
                    end
                end
                S_PREP: begin
                    ma_r    <= prep_ma_s;
                    mb_r    <= prep_mb_s;
                    neg_q_r <= op_r[0] & (rs_r[31] ^ rt_r[31]);
                    neg_r_r <= op_r[0] & rs_r[31];
                    dz_r    <= op_r[1] & (rt_r == 32'd0);
                    w_hi_r  <= 32'd0;
                    w_lo_r  <= op_r[1] ? prep_ma_s : prep_mb_s;
                    cnt_r   <= 5'd0;
                end
                S_ITER: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_r[1]) begin
                        if (div_take_s) begin
                            w_hi_r <= alu_s;
                            w_lo_r <= {w_lo_r[30:0], 1'b1};
                        end else begin
                            w_hi_r <= div_t_s;
                            w_lo_r <= {w_lo_r[30:0], 1'b0};
                        end
                    end else begin
                        w_hi_r <= {mul_carry_s, alu_s[31:1]};
                        w_lo_r <= {alu_s[0], w_lo_r[31:1]};
                    end
                end
                S_FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (dz_r) begin
                        hi_r <= rs_r;
                        lo_r <= 32'hFFFF_FFFF;
                    end else if (op_r[1]) begin
                        lo_r <= neg_q_r ? neg32(w_lo_r) : w_lo_r;
                        hi_r <= neg_r_r ? neg32(w_hi_r) : w_hi_r;
                    end else begin
                        {hi_r, lo_r} <= neg_q_r ? neg64({w_hi_r, w_lo_r}) : {w_hi_r, w_lo_r};
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign alu_sel  = alu_sel_s;
    assign alu_a    = alu_a_s;
    assign alu_b    = alu_b_s;
    assign alu_fun  = alu_fun_s;
    assign alu_sign = 1'b0;

endmodule
